// File: rtl/player_pkg.sv
// Shared types, keycodes and floor/position helpers for the player motion block.
package player_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    CLIMB  = 2'd1,
    JUMP   = 2'd2
  } pstate_t;

  localparam logic [7:0] KEY_W    = 8'h1A;
  localparam logic [7:0] KEY_S    = 8'h16;
  localparam logic [7:0] KEY_A    = 8'h04;
  localparam logic [7:0] KEY_D    = 8'h07;
  localparam logic [7:0] KEY_JUMP = 8'h2C;

  function automatic logic [9:0] floor_y(input logic [2:0]  level,
                                         input int unsigned base_y,
                                         input int unsigned pitch);
    return 10'(base_y - 32'(level) * pitch);
  endfunction

  // Add a small signed step to X and clamp to [lo, hi] without wrapping.
  function automatic logic [9:0] sat_x(input logic [9:0]        x,
                                       input logic signed [3:0] dx,
                                       input logic [9:0]        lo,
                                       input logic [9:0]        hi);
    logic signed [11:0] s;
    s = $signed({2'b00, x}) + $signed({{8{dx[3]}}, dx});
    if (s < $signed({2'b00, lo})) return lo;
    if (s > $signed({2'b00, hi})) return hi;
    return s[9:0];
  endfunction

endpackage

// File: rtl/player_ladder_lookup.sv
// Combinational ladder table lookup: which ladder the player stands at and the
// floor heights immediately above and below the current floor.
module player_ladder_lookup
  import player_pkg::*;
#(
  parameter int unsigned                   NUM_LEVELS  = 6,
  parameter int unsigned                   BASE_Y      = 414,
  parameter int unsigned                   LEVEL_PITCH = 60,
  parameter int unsigned                   NUM_LADDERS = 8,
  parameter logic [NUM_LADDERS*10-1:0]     LADDER_X    = {10'd535, 10'd320, 10'd120, 10'd500,
                                                          10'd250, 10'd100, 10'd535, 10'd300},
  parameter logic [NUM_LADDERS*3-1:0]      LADDER_LVL  = {3'd4, 3'd3, 3'd3, 3'd2,
                                                          3'd2, 3'd1, 3'd0, 3'd0},
  parameter int unsigned                   LADDER_W    = 15
) (
  input  logic [9:0] PlayerX,
  input  logic [2:0] cur_level,
  output logic       up_ok,
  output logic       dn_ok,
  output logic [9:0] upper_y,
  output logic [9:0] lower_y
);

  logic top_ok;
  assign top_ok = (int'(cur_level) + 1) < int'(NUM_LEVELS);

  // Scan from the highest index down so the lowest-index matching ladder wins.
  always_comb begin
    up_ok = 1'b0;
    dn_ok = 1'b0;
    for (int j = int'(NUM_LADDERS) - 1; j >= 0; j--) begin
      logic [9:0] lx;
      logic [2:0] lvl;
      logic       hit, is_up, is_dn;
      lx    = LADDER_X[10*j +: 10];
      lvl   = LADDER_LVL[3*j +: 3];
      hit   = ({1'b0, PlayerX} > {1'b0, lx}) &&
              ({1'b0, PlayerX} < ({1'b0, lx} + 11'(LADDER_W)));
      is_up = hit && (lvl == cur_level) && top_ok;
      is_dn = hit && (({1'b0, lvl} + 4'd1) == {1'b0, cur_level});
      if (is_up || is_dn) begin
        up_ok = is_up;
        dn_ok = is_dn;
      end
    end
  end

  assign upper_y = floor_y(cur_level + 3'd1, BASE_Y, LEVEL_PITCH);
  assign lower_y = floor_y((cur_level == 3'd0) ? 3'd0 : cur_level - 3'd1, BASE_Y, LEVEL_PITCH);

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-frame player movement: walk, ladder climb and gravity jump over a fixed
// floor/ladder layout, driven by up to NUM_KEYS simultaneous USB keycodes.
module player_motion_ctrl
  import player_pkg::*;
#(
  parameter int unsigned               NUM_KEYS    = 2,
  parameter int unsigned               NUM_LEVELS  = 6,
  parameter int unsigned               BASE_Y      = 414,
  parameter int unsigned               LEVEL_PITCH = 60,
  parameter int unsigned               NUM_LADDERS = 8,
  parameter logic [NUM_LADDERS*10-1:0] LADDER_X    = {10'd535, 10'd320, 10'd120, 10'd500,
                                                      10'd250, 10'd100, 10'd535, 10'd300},
  parameter logic [NUM_LADDERS*3-1:0]  LADDER_LVL  = {3'd4, 3'd3, 3'd3, 3'd2,
                                                      3'd2, 3'd1, 3'd0, 3'd0},
  parameter int unsigned               LADDER_W    = 15,
  parameter int unsigned               X_START     = 50,
  parameter int unsigned               X_MIN       = 0,
  parameter int unsigned               X_MAX       = 623,
  parameter int unsigned               X_STEP      = 2,
  parameter int unsigned               CLIMB_STEP  = 1,
  parameter int unsigned               JUMP_V      = 4,
  parameter int unsigned               SIZE        = 16
) (
  input  logic                  frame_clk,
  input  logic                  Reset,
  input  logic [NUM_KEYS*8-1:0] keycodes,
  output logic [9:0]            PlayerX,
  output logic [9:0]            PlayerY,
  output logic [9:0]            PlayerS,
  output pstate_t               state,
  output logic                  facing_left,
  output logic [2:0]            cur_level
);

  localparam logic signed [3:0] WalkStep = 4'(X_STEP);
  localparam logic signed [5:0] JumpVy   = 6'(-int'(JUMP_V));
  localparam logic [9:0]        ClimbDy  = 10'(CLIMB_STEP);

  logic              key_w, key_s, key_a, key_d, key_j;
  logic              up_ok, dn_ok;
  logic [9:0]        upper_y, lower_y, floor_here, top_y, bot_y;
  logic signed [5:0] vy;
  logic signed [3:0] jump_dx, walk_dx;
  logic              climb_dn;
  logic [9:0]        x_walk, x_jump, y_jump;
  logic              land;

  always_comb begin
    key_w = 1'b0;
    key_s = 1'b0;
    key_a = 1'b0;
    key_d = 1'b0;
    key_j = 1'b0;
    for (int k = 0; k < int'(NUM_KEYS); k++) begin
      if (keycodes[8*k +: 8] != 8'h00) begin
        if (keycodes[8*k +: 8] == KEY_W)    key_w = 1'b1;
        if (keycodes[8*k +: 8] == KEY_S)    key_s = 1'b1;
        if (keycodes[8*k +: 8] == KEY_A)    key_a = 1'b1;
        if (keycodes[8*k +: 8] == KEY_D)    key_d = 1'b1;
        if (keycodes[8*k +: 8] == KEY_JUMP) key_j = 1'b1;
      end
    end
  end

  player_ladder_lookup #(
    .NUM_LEVELS  (NUM_LEVELS),
    .BASE_Y      (BASE_Y),
    .LEVEL_PITCH (LEVEL_PITCH),
    .NUM_LADDERS (NUM_LADDERS),
    .LADDER_X    (LADDER_X),
    .LADDER_LVL  (LADDER_LVL),
    .LADDER_W    (LADDER_W)
  ) u_ladder (
    .PlayerX   (PlayerX),
    .cur_level (cur_level),
    .up_ok     (up_ok),
    .dn_ok     (dn_ok),
    .upper_y   (upper_y),
    .lower_y   (lower_y)
  );

  assign floor_here = floor_y(cur_level, BASE_Y, LEVEL_PITCH);
  // cur_level stays on the departure floor while climbing, so the ladder's
  // span depends on which way the climb started.
  assign top_y      = climb_dn ? floor_here : upper_y;
  assign bot_y      = climb_dn ? lower_y : floor_here;

  assign walk_dx = (key_a && !key_d) ? -WalkStep :
                   (key_d && !key_a) ?  WalkStep : 4'sd0;
  assign x_walk  = sat_x(PlayerX, walk_dx, 10'(X_MIN), 10'(X_MAX));
  assign x_jump  = sat_x(PlayerX, jump_dx, 10'(X_MIN), 10'(X_MAX));
  assign y_jump  = PlayerY + {{4{vy[5]}}, vy};
  assign land    = (vy > 6'sd0) && (y_jump >= floor_here);
  assign PlayerS = 10'(SIZE);

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      PlayerX     <= 10'(X_START);
      PlayerY     <= 10'(BASE_Y);
      state       <= GROUND;
      facing_left <= 1'b0;
      cur_level   <= 3'd0;
      vy          <= 6'sd0;
      jump_dx     <= 4'sd0;
      climb_dn    <= 1'b0;
    end else begin
      case (state)
        GROUND: begin
          if (key_j) begin
            state   <= JUMP;
            vy      <= JumpVy;
            jump_dx <= walk_dx;
          end else if (key_w && up_ok) begin
            state    <= CLIMB;
            PlayerY  <= PlayerY - ClimbDy;
            climb_dn <= 1'b0;
          end else if (key_s && dn_ok) begin
            state    <= CLIMB;
            PlayerY  <= PlayerY + ClimbDy;
            climb_dn <= 1'b1;
          end else begin
            PlayerX <= x_walk;
            if (key_a && !key_d)      facing_left <= 1'b1;
            else if (key_d && !key_a) facing_left <= 1'b0;
          end
        end
        CLIMB: begin
          if (key_w && !key_s) begin
            if (PlayerY - ClimbDy <= top_y) begin
              PlayerY   <= top_y;
              state     <= GROUND;
              cur_level <= climb_dn ? cur_level : cur_level + 3'd1;
            end else begin
              PlayerY <= PlayerY - ClimbDy;
            end
          end else if (key_s && !key_w) begin
            if (PlayerY + ClimbDy >= bot_y) begin
              PlayerY   <= bot_y;
              state     <= GROUND;
              cur_level <= climb_dn ? cur_level - 3'd1 : cur_level;
            end else begin
              PlayerY <= PlayerY + ClimbDy;
            end
          end
        end
        JUMP: begin
          PlayerX <= x_jump;
          if (land) begin
            PlayerY <= floor_here;
            vy      <= 6'sd0;
            jump_dx <= 4'sd0;
            state   <= GROUND;
          end else begin
            PlayerY <= y_jump;
            vy      <= vy + 6'sd1;
          end
        end
        default: state <= GROUND;
      endcase
    end
  end

  assert property (@(posedge frame_clk) disable iff (Reset) (PlayerY <= 10'(BASE_Y)));
  assert property (@(posedge frame_clk) disable iff (Reset) (int'(cur_level) < int'(NUM_LEVELS)));

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl: table-driven frame vectors plus
// hand-written jump and mid-motion reset sequences.
module tb_player_motion_ctrl;
  import player_pkg::*;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [15:0] keycodes;
  logic [9:0]  PlayerX, PlayerY, PlayerS;
  pstate_t     state;
  logic        facing_left;
  logic [2:0]  cur_level;

  int checks = 0;
  int errors = 0;

  always #5 frame_clk = ~frame_clk;

  player_motion_ctrl dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .keycodes    (keycodes),
    .PlayerX     (PlayerX),
    .PlayerY     (PlayerY),
    .PlayerS     (PlayerS),
    .state       (state),
    .facing_left (facing_left),
    .cur_level   (cur_level)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [15:0] keys;
    int          reps;
    int          x;
    int          y;
    pstate_t     st;
    int          fl;
    int          lvl;
  } vec_t;

  vec_t vecs[$];
  int   jump_y[9] = '{410, 407, 405, 404, 404, 405, 407, 410, 414};

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input int x, input int y, input pstate_t st,
                           input int fl, input int lvl);
    check({nm, ".x"}, int'(PlayerX), x);
    check({nm, ".y"}, int'(PlayerY), y);
    check({nm, ".state"}, int'(state), int'(st));
    check({nm, ".facing"}, int'(facing_left), fl);
    check({nm, ".level"}, int'(cur_level), lvl);
  endtask

  // Hold inputs for n active edges, then return 1 time unit after the last edge.
  task automatic frames(input logic rst, input logic [15:0] k, input int n);
    Reset    = rst;
    keycodes = k;
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  task automatic add(input string nm, input logic rst, input logic [15:0] k, input int reps,
                     input int x, input int y, input pstate_t st, input int fl, input int lvl);
    vec_t v;
    v.name = nm; v.rst = rst; v.keys = k; v.reps = reps;
    v.x = x; v.y = y; v.st = st; v.fl = fl; v.lvl = lvl;
    vecs.push_back(v);
  endtask

  initial begin
    Reset    = 1'b1;
    keycodes = 16'h0000;

    add("rst",        1, 16'h0000,   1,  50, 414, GROUND, 0, 0);
    add("walk_d",     0, 16'h0007,  10,  70, 414, GROUND, 0, 0);
    add("a_and_d",    0, 16'h0407,   5,  70, 414, GROUND, 0, 0);
    add("walk_a",     0, 16'h0004,   1,  68, 414, GROUND, 1, 0);
    add("d_sat_max",  0, 16'h0700, 300, 623, 414, GROUND, 0, 0);
    add("a_to_307",   0, 16'h0400, 158, 307, 414, GROUND, 1, 0);
    add("climb_1",    0, 16'h001A,   1, 307, 413, CLIMB,  1, 0);
    add("climb_a",    0, 16'h1A04,   1, 307, 412, CLIMB,  1, 0);
    add("climb_ws",   0, 16'h1A16,   3, 307, 412, CLIMB,  1, 0);
    add("climb_57",   0, 16'h001A,  57, 307, 355, CLIMB,  1, 0);
    add("climb_top",  0, 16'h001A,   1, 307, 354, GROUND, 1, 1);
    add("w_above",    0, 16'h001A,   3, 307, 354, GROUND, 1, 1);
    add("down_1",     0, 16'h0016,   1, 307, 355, CLIMB,  1, 1);
    add("down_bot",   0, 16'h0016,  59, 307, 414, GROUND, 1, 0);
    add("rst2",       1, 16'h0016,   1,  50, 414, GROUND, 0, 0);
    add("to_200",     0, 16'h0007,  75, 200, 414, GROUND, 0, 0);
    add("s_no_lad",   0, 16'h0016,   3, 200, 414, GROUND, 0, 0);
    add("w_no_lad",   0, 16'h1A00,   2, 200, 414, GROUND, 0, 0);
    add("to_623",     0, 16'h0007, 250, 623, 414, GROUND, 0, 0);
    add("to_1",       0, 16'h0004, 311,   1, 414, GROUND, 1, 0);
    add("a_sat_min",  0, 16'h0004,   1,   0, 414, GROUND, 1, 0);
    add("a_hold_min", 0, 16'h0004,   3,   0, 414, GROUND, 1, 0);
    add("rst3",       1, 16'h0000,   1,  50, 414, GROUND, 0, 0);
    add("to_300",     0, 16'h0007, 125, 300, 414, GROUND, 0, 0);
    add("w_edge",     0, 16'h001A,   2, 300, 414, GROUND, 0, 0);
    add("to_302",     0, 16'h0007,   1, 302, 414, GROUND, 0, 0);
    add("w_in_lad",   0, 16'h001A,   1, 302, 413, CLIMB,  0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      frames(vecs[i].rst, vecs[i].keys, vecs[i].reps);
      check_all(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].st, vecs[i].fl, vecs[i].lvl);
    end
    check("size", int'(PlayerS), 16);

    // Jump with D; switch to A mid-flight, which must have no effect.
    frames(1, 16'h0000, 1);
    frames(0, 16'h2C07, 1);
    check_all("jmp_start", 50, 414, JUMP, 0, 0);
    for (int i = 0; i < 9; i++) begin
      frames(0, (i >= 5) ? 16'h0004 : 16'h2C07, 1);
      check("jmp_y", int'(PlayerY), jump_y[i]);
      check("jmp_x", int'(PlayerX), 52 + 2 * i);
      check("jmp_state", int'(state), (i == 8) ? int'(GROUND) : int'(JUMP));
    end
    frames(0, 16'h0000, 1);
    check_all("jmp_land", 68, 414, GROUND, 0, 0);

    // Reset in the middle of a climb on ladder 1.
    frames(1, 16'h0000, 1);
    frames(0, 16'h0007, 243);
    check("clb_x", int'(PlayerX), 536);
    frames(0, 16'h001A, 34);
    check("clb_y", int'(PlayerY), 380);
    check("clb_state", int'(state), int'(CLIMB));
    frames(1, 16'h001A, 1);
    check_all("rst_climb", 50, 414, GROUND, 0, 0);

    // Straight-up jump, reset near the apex.
    frames(0, 16'h002C, 1);
    frames(0, 16'h0000, 3);
    check("mj_y", int'(PlayerY), 405);
    check("mj_x", int'(PlayerX), 50);
    check("mj_state", int'(state), int'(JUMP));
    frames(1, 16'h002C, 1);
    check_all("rst_jump", 50, 414, GROUND, 0, 0);
    frames(0, 16'h0000, 2);
    check_all("post_rst", 50, 414, GROUND, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
